// File: rtl/pattern_scan_sched.sv
// pattern_scan_sched
//   Round-robin scheduler that shares one serial pattern-scan engine among
//   NREQ requesters. The granted requester's word is shifted out MSB-first
//   while a three-state odd-run tracker (S0/S1/S2) counts hits. A hit is
//   every bit that moves the tracker into S1. The hit count is reported
//   together with the requester ID.
//
//   Configuration macro:
//     PATTERN_SCHED_FIXED_PRIO_EN  defined: fixed priority, where the lowest
//                                  active index always wins.
//                                  undefined (default): round-robin, with the
//                                  search starting after the last grant.
//
//   Ports:
//     clk        clock; all state changes on its rising edge
//     reset      asynchronous, active-high reset
//     req        per-requester request level [NREQ]
//     data       requester i word on bits [i*DATA_W +: DATA_W]
//     gnt        one-hot grant, one-cycle pulse after the grant edge
//     busy       high while the engine is not idle
//     sx         serial bit, MSB first (0 when sv=0)
//     sv         serial bit valid
//     done       one-cycle result strobe
//     done_id    ID of the requester just served (held until next grant)
//     hit_count  hits counted for that word (cleared at the next grant)
module pattern_scan_sched #(
  parameter  int NREQ   = 4,
  parameter  int DATA_W = 8,
  localparam int IDW    = $clog2(NREQ),
  localparam int CW     = $clog2(DATA_W + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*DATA_W-1:0]   data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     sx,
  output logic                     sv,
  output logic                     done,
  output logic [IDW-1:0]           done_id,
  output logic [CW-1:0]            hit_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    TS0 = 2'd0,
    TS1 = 2'd1,
    TS2 = 2'd2
  } trk_t;

  state_t              state;
  state_t              state_next;
  trk_t                trk;
  trk_t                trk_nxt;
  logic                grant_en;
  logic [IDW-1:0]      sel_id;
  logic [NREQ-1:0]     sel_onehot;
  logic [DATA_W-1:0]   sel_word;
  logic [DATA_W-1:0]   shreg;
  logic [CW-1:0]       bit_cnt;
`ifndef PATTERN_SCHED_FIXED_PRIO_EN
  logic [IDW-1:0]      last_id;
`endif

  // Odd-run tracker step for one serial bit.
  function automatic trk_t trk_step(input trk_t cur, input logic b);
    trk_t nxt;
    nxt = TS0;
    case (cur)
      TS0:     nxt = b ? TS1 : TS0;
      TS1:     nxt = b ? TS2 : TS0;
      TS2:     nxt = b ? TS1 : TS0;
      default: nxt = TS0;
    endcase
    return nxt;
  endfunction

  // Saturating increment of the hit counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    if (v == {CW{1'b1}}) r = v;
    else                 r = v + 1'b1;
    return r;
  endfunction

  // Arbitration. The loop walks from lowest to highest priority so the
  // last match (highest priority) wins without a separate found flag.
  always_comb begin : arbiter
    int idx;
    idx    = 0;
    sel_id = '0;
`ifdef PATTERN_SCHED_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) sel_id = IDW'(i);
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_id) + k) % NREQ;
      if (req[idx]) sel_id = IDW'(idx);
    end
`endif
    sel_word   = '0;
    sel_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (IDW'(i) == sel_id) begin
        sel_word      = data[i*DATA_W +: DATA_W];
        sel_onehot[i] = 1'b1;
      end
    end
  end

  // Scheduler state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Scheduler next-state and status outputs.
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    busy       = 1'b0;
    sv         = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          grant_en   = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        sv   = 1'b1;
        if (bit_cnt == CW'(DATA_W - 1)) state_next = REPORT;
      end
      REPORT: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign trk_nxt = trk_step(trk, shreg[DATA_W-1]);
  assign sx      = sv & shreg[DATA_W-1];

  // Grant, tracker, counters and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt       <= '0;
      done_id   <= '0;
      hit_count <= '0;
      trk       <= TS0;
      bit_cnt   <= '0;
`ifndef PATTERN_SCHED_FIXED_PRIO_EN
      last_id   <= IDW'(NREQ - 1);
`endif
    end else begin
      gnt <= grant_en ? sel_onehot : '0;
      if (grant_en) begin
        done_id   <= sel_id;
        hit_count <= '0;
        trk       <= TS0;
        bit_cnt   <= '0;
`ifndef PATTERN_SCHED_FIXED_PRIO_EN
        last_id   <= sel_id;
`endif
      end else if (state == SHIFT) begin
        trk     <= trk_nxt;
        bit_cnt <= bit_cnt + 1'b1;
        if (trk_nxt == TS1) hit_count <= sat_inc(hit_count);
      end
    end
  end

  // Shift register carries data only; a stale word is harmless because sx
  // is gated by sv.
  always_ff @(posedge clk) begin
    if (grant_en)            shreg <= sel_word;
    else if (state == SHIFT) shreg <= {shreg[DATA_W-2:0], 1'b0};
  end

endmodule

// File: tb/tb_pattern_scan_sched.sv
module tb_pattern_scan_sched;
  localparam int NREQ = 4;
  localparam int DW   = 8;
  localparam int IDW  = $clog2(NREQ);
  localparam int CW   = $clog2(DW + 1);

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req;
  logic [NREQ*DW-1:0]   data;
  logic [NREQ-1:0]      gnt;
  logic                 busy, sx, sv, done;
  logic [IDW-1:0]       done_id;
  logic [CW-1:0]        hit_count;

  pattern_scan_sched #(.NREQ(NREQ), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .req(req), .data(data), .gnt(gnt),
    .busy(busy), .sx(sx), .sv(sv), .done(done), .done_id(done_id),
    .hit_count(hit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            id;
    int            hits;
    logic [DW-1:0] word;
    int            gcyc;
  } exp_t;

  exp_t            q[$];
  int              checks = 0;
  int              errors = 0;
  int              cyc = 0;
  int              done_cnt = 0;
  logic [NREQ-1:0] act = '0;
  int              model_last = NREQ - 1;
  bit              prev_valid = 0;
  int              prev_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: hits = sum over maximal runs of ones of ceil(len/2).
  function automatic int ref_hits(input logic [DW-1:0] w);
    int run, h;
    run = 0; h = 0;
    for (int i = DW - 1; i >= 0; i--) begin
      if (w[i]) run++;
      else begin h += (run + 1) / 2; run = 0; end
    end
    h += (run + 1) / 2;
    return h;
  endfunction

  function automatic int ref_pick(input logic [NREQ-1:0] a, input int last);
`ifdef PATTERN_SCHED_FIXED_PRIO_EN
    for (int i = 0; i < NREQ; i++) if (a[i]) return i;
`else
    for (int k = 1; k <= NREQ; k++) if (a[(last + k) % NREQ]) return (last + k) % NREQ;
`endif
    return -1;
  endfunction

  function automatic logic [NREQ*DW-1:0] rand_words();
    logic [NREQ*DW-1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Monitor: serial capture, protocol relations and scoreboard pop on done.
  logic [DW-1:0] bits = '0;
  int            nsv = 0;
  logic          gnt_prev = 1'b0;
  exp_t          e;

  always @(negedge clk) begin
    if (reset) begin
      nsv      = 0;
      gnt_prev = 1'b0;
    end else begin
      checks++;
      if (busy !== (sv | done)) begin
        errors++;
        $display("FAIL busy got=%b want=%b", busy, sv | done);
      end
      if (sv) begin
        bits = {bits[DW-2:0], sx};
        nsv++;
      end else begin
        checks++;
        if (sx !== 1'b0) begin errors++; $display("FAIL sx_idle got=%b want=0", sx); end
      end
      if (gnt != '0) begin
        checks++;
        if (gnt_prev || $countones(gnt) != 1) begin
          errors++;
          $display("FAIL gnt_pulse got=%b prev=%b want=single one-hot pulse", gnt, gnt_prev);
        end
      end
      gnt_prev = |gnt;
      if (done) begin
        done_cnt++;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done id=%0d hits=%0d want=no done", done_id, hit_count);
        end else begin
          e = q.pop_front();
          if (done_id !== IDW'(e.id) || hit_count !== CW'(e.hits)) begin
            errors++;
            $display("FAIL result got id=%0d hits=%0d want id=%0d hits=%0d",
                     done_id, hit_count, e.id, e.hits);
          end
          checks++;
          if (bits !== e.word || nsv != DW) begin
            errors++;
            $display("FAIL serial got=%h bits=%0d want=%h bits=%0d", bits, nsv, e.word, DW);
          end
          checks++;
          if (cyc != e.gcyc + DW) begin
            errors++;
            $display("FAIL done_time got=%0d want=%0d", cyc - e.gcyc, DW);
          end
        end
        nsv = 0;
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({gnt, busy, sx, sv, done, done_id, hit_count} !== '0) begin
      errors++;
      $display("FAIL %s got gnt=%b busy=%b sx=%b sv=%b done=%b id=%0d hits=%0d want all 0",
               name, gnt, busy, sx, sv, done, done_id, hit_count);
    end
  endtask

  task automatic idle(input int n);
    prev_valid = 0;
    repeat (n) @(negedge clk);
  endtask

  // Add requesters, wait for the next grant and record the expected result.
  task automatic episode(input logic [NREQ-1:0] add, input logic [NREQ*DW-1:0] wds);
    int            exp_id, n;
    logic [DW-1:0] w;
    for (int i = 0; i < NREQ; i++) begin
      if (add[i] && !act[i]) begin
        act[i] = 1'b1;
        data[i*DW +: DW] = wds[i*DW +: DW];
      end
    end
    req = act;
    if (act == '0) begin prev_valid = 0; return; end
    exp_id = ref_pick(act, model_last);
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 60);
    checks++;
    if (gnt !== (NREQ'(1) << exp_id)) begin
      errors++;
      $display("FAIL grant got=%b want=%b", gnt, NREQ'(1) << exp_id);
    end
    if (gnt == '0) begin prev_valid = 0; return; end
    w = data[exp_id*DW +: DW];
    q.push_back('{exp_id, ref_hits(w), w, cyc});
    if (prev_valid) begin
      checks++;
      if (cyc - prev_cyc != DW + 2) begin
        errors++;
        $display("FAIL period got=%0d want=%0d", cyc - prev_cyc, DW + 2);
      end
    end
    prev_valid = 1;
    prev_cyc   = cyc;
    act[exp_id] = 1'b0;
    req         = act;
    model_last  = exp_id;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (act != '0 && guard < 2 * NREQ) begin
      episode('0, '0);
      guard++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [NREQ*DW-1:0] wd;
    int d0;
    reset = 1'b0;
    req   = '0;
    data  = '0;
    #1 reset = 1'b1;
    #1 check_zero("reset_async");
    repeat (2) @(negedge clk);
    check_zero("reset_hold");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Known words back-to-back: F6 on requester 2, then FF, 00, AA on 0.
    wd = '0; wd[2*DW +: DW] = 8'hF6;
    episode(4'b0100, wd);
    wd = '0; wd[0 +: DW] = 8'hFF;
    episode(4'b0001, wd);
    wd = '0; wd[0 +: DW] = 8'h00;
    episode(4'b0001, wd);
    wd = '0; wd[0 +: DW] = 8'hAA;
    episode(4'b0001, wd);
    idle(12);

    // All requesters held continuously.
    for (int i = 0; i < 5; i++) episode(4'b1111, rand_words());
    drain();
    idle(12);

    // Requesters 1 and 3 held.
    for (int i = 0; i < 4; i++) episode(4'b1010, rand_words());
    drain();
    idle(12);

    // Requester 3 arrives mid-shift of requester 0.
    episode(4'b0001, rand_words());
    repeat (3) @(negedge clk);
    episode(4'b1000, rand_words());
    idle(12);

    // Reset during the fourth serial cycle drops the word in flight.
    episode(4'b0100, rand_words());
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    #1 check_zero("reset_midword");
    q.delete();
    act = '0;
    req = '0;
    repeat (2) @(negedge clk);
    reset      = 1'b0;
    model_last = NREQ - 1;
    prev_valid = 0;
    d0 = done_cnt;
    repeat (12) @(negedge clk);
    checks++;
    if (done_cnt != d0) begin
      errors++;
      $display("FAIL done_after_reset got=%0d want=0", done_cnt - d0);
    end
    check_zero("post_reset_idle");
    episode(4'b0010, rand_words());

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 15));
      episode(NREQ'($urandom_range(0, (1 << NREQ) - 1)), rand_words());
    end
    drain();

    repeat (DW + 4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL pending_results got=%0d want=0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
